regfile_sb: RTL
===============

Name: regfile_sb

Overview:
- Architectural register file: 32 x 32-bit GPRs plus a pending-write scoreboard.
- Receiving end of the writeback stage's register-write interface: it consumes wren/waddr/wdata and commits them to architectural state.
- Serves two combinational read ports to decode.
- Tracks registers with an outstanding load write so decode can raise an interlock.

Parameters:
- NREG, 32, number of GPRs; R0 hardwired zero.
- AW, 5, register address width (log2 NREG).
- DW, 32, data width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous reset, active-high. The name is kept per codebase convention; the polarity is high.
- wb_wren_i  in  1  write enable from writeback.
- wb_waddr_i  in  AW  write register index.
- wb_wdata_i  in  DW  write data.
- rd1_addr_i  in  AW  read port 1 index.
- rd2_addr_i  in  AW  read port 2 index.
- rd1_data_o  out  DW  read port 1 data.
- rd2_data_o  out  DW  read port 2 data.
- rd1_busy_o  out  1  read port 1 register has a pending write.
- rd2_busy_o  out  1  read port 2 register has a pending write.
- sb_set_i  in  1  decode issues an instruction with a long-latency (load) destination.
- sb_addr_i  in  AW  destination index for sb_set_i.
- sb_flush_i  in  1  pipeline flush: clear every busy bit.
- busy_cnt_o  out  AW+1  number of registers currently busy (0..31).

Behaviour:
- Reset (async, rst_n=1):
  - All GPRs = 0, all busy bits = 0, busy_cnt_o = 0.
  - Read data returns 0 during reset; the bypass is inhibited.
- Write:
  - On a rising edge with wb_wren_i=1 and wb_waddr_i!=0, GPR[wb_waddr_i] <= wb_wdata_i.
  - Writes to R0 are dropped.
- Read:
  - Combinational, zero-cycle.
  - rdN_data_o = 0 if rdN_addr_i==0.
  - Otherwise, if wb_wren_i && wb_waddr_i==rdN_addr_i, output wb_wdata_i (write-through bypass).
  - Otherwise output GPR[rdN_addr_i].
  - Both ports may read the same index; both receive identical data.
- Scoreboard, one busy bit per register (bit 0 constant 0). Priority each cycle:
  1. sb_flush_i=1: all bits <= 0. Any sb_set_i that cycle is ignored.
  2. Otherwise, clear bit[wb_waddr_i] when wb_wren_i=1.
  3. Then set bit[sb_addr_i] when sb_set_i=1 and sb_addr_i!=0.
  - Set and clear to the same index in one cycle leaves the bit set: the new producer wins.
  - Setting an already-busy bit leaves it busy. Count is unchanged; no nesting depth is tracked.
  - A clear to a non-busy register has no effect.
- rdN_busy_o:
  - = busy[rdN_addr_i] && !(wb_wren_i && wb_waddr_i==rdN_addr_i).
  - The same-cycle writeback resolves the hazard through the bypass, so busy is not raised.
  - Always 0 for index 0.
- busy_cnt_o:
  - Registered population count of the busy vector after the update.
  - Valid one cycle after the causing edge, i.e. it reflects the current register state.
  - Range 0..31, never wraps.
- No internal stall: writeback gates wb_wren_i with its own stall/flush before presenting it.

Decomposition:
- Shared package/defines holds: register address width, REG_ZERO index constant, data-width macro, reused by decode and writeback.
- One natural sub-module, sb_popcount: 32-bit busy vector to a 6-bit count, combinational, then registered in the parent.
- Storage array, bypass muxes and busy vector stay in regfile_sb.

Test Plan:
- Reset/R0:
  - Assert rst_n mid-cycle after writing R5=0x1234 -> R5 reads 0 immediately, busy_cnt_o=0.
  - Write R0=0xFFFFFFFF -> rd1 of R0 reads 0.
- Bypass:
  - wren=1, waddr=7, wdata=0xDEADBEEF, rd1_addr=rd2_addr=7 in the same cycle -> both ports read 0xDEADBEEF before the edge.
  - Next cycle with wren=0 -> still 0xDEADBEEF.
- Scoreboard set/clear:
  - sb_set R9 -> next cycle rd1_busy(R9)=1, busy_cnt=1.
  - Writeback to R9 -> busy drops combinationally in that cycle; after the edge bit=0, busy_cnt=0.
- Simultaneous set and clear on R3 -> R3 stays busy, busy_cnt unchanged at 1.
- Flush:
  - Set R1, R2, R31, then sb_flush with a concurrent sb_set R4 -> all busy=0, busy_cnt=0, R4 not busy.
- Saturation:
  - Set R1..R31 on consecutive cycles -> busy_cnt=31.
  - An extra set on R1 -> busy_cnt remains 31.
  - sb_set R0 -> ignored.

Source files
------------

// File: rtl/regfile_sb_pkg.sv
// Shared definitions for the architectural register file and its scoreboard.
// Decode and writeback import the same package so register indices and
// data widths stay consistent across the pipeline.

`ifndef REGFILE_SB_DW
`define REGFILE_SB_DW 32
`endif

package regfile_sb_pkg;

  // Geometry of the GPR file
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int DW   = `REGFILE_SB_DW;

  // R0 is hardwired to zero and never busy
  localparam logic [AW-1:0] REG_ZERO = '0;

  typedef logic [AW-1:0]   reg_addr_t;
  typedef logic [DW-1:0]   reg_data_t;
  typedef logic [NREG-1:0] busy_vec_t;
  typedef logic [AW:0]     busy_cnt_t;

  // True for the hardwired-zero register
  function automatic logic is_zero_reg(input reg_addr_t addr);
    return (addr == REG_ZERO);
  endfunction

  // One-hot decode of a register index into a busy-vector mask
  function automatic busy_vec_t reg_mask(input reg_addr_t addr);
    busy_vec_t m;
    m       = '0;
    m[addr] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Register-file bus: writeback write port, two decode read ports and the
// decode-side scoreboard controls.
//
// Handshake semantics: there is no ready/backpressure on any channel. Each
// *_i qualifier (wb_wren_i, sb_set_i, sb_flush_i) is a single-cycle strobe
// sampled on the rising edge of clk; the associated address/data are only
// meaningful while the strobe is high. Read ports are purely combinational:
// data and busy follow the read address in the same cycle.

interface regfile_sb_if;
  import regfile_sb_pkg::*;

  // Writeback write port
  logic      wb_wren_i;
  reg_addr_t wb_waddr_i;
  reg_data_t wb_wdata_i;

  // Decode read ports
  reg_addr_t rd1_addr_i;
  reg_addr_t rd2_addr_i;
  reg_data_t rd1_data_o;
  reg_data_t rd2_data_o;
  logic      rd1_busy_o;
  logic      rd2_busy_o;

  // Scoreboard control from decode / pipeline control
  logic      sb_set_i;
  reg_addr_t sb_addr_i;
  logic      sb_flush_i;
  busy_cnt_t busy_cnt_o;

  // Pipeline side: drives writes, read indices and scoreboard controls
  modport master (
    output wb_wren_i, wb_waddr_i, wb_wdata_i,
    output rd1_addr_i, rd2_addr_i,
    output sb_set_i, sb_addr_i, sb_flush_i,
    input  rd1_data_o, rd2_data_o, rd1_busy_o, rd2_busy_o, busy_cnt_o
  );

  // Register file side
  modport slave (
    input  wb_wren_i, wb_waddr_i, wb_wdata_i,
    input  rd1_addr_i, rd2_addr_i,
    input  sb_set_i, sb_addr_i, sb_flush_i,
    output rd1_data_o, rd2_data_o, rd1_busy_o, rd2_busy_o, busy_cnt_o
  );

endinterface

// File: rtl/regfile_sb_popcount.sv
// Combinational population count of the scoreboard busy vector.
// The result is registered by the parent.

module sb_popcount
  import regfile_sb_pkg::*;
(
  input  busy_vec_t vec_i,
  output busy_cnt_t cnt_o
);

  // Sum every busy bit; width AW+1 holds the full 0..NREG range
  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < NREG; i++) begin
      cnt_o = cnt_o + {{AW{1'b0}}, vec_i[i]};
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Architectural register file (32 x 32-bit, R0 = 0) with write-through
// bypass on both read ports and a pending-load scoreboard used by decode
// to raise interlocks.

module regfile_sb
  import regfile_sb_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,   // active-high asynchronous reset
  regfile_sb_if.slave  bus
);

  // Architectural state
  reg_data_t gpr_q [NREG];
  busy_vec_t busy_q;
  busy_vec_t busy_d;
  busy_cnt_t busy_cnt_q;
  busy_cnt_t busy_cnt_d;

  // Write qualification: R0 writes are dropped
  logic wr_en;
  assign wr_en = bus.wb_wren_i && !is_zero_reg(bus.wb_waddr_i);

  // Read-port hazard terms
  logic rd1_hit;
  logic rd2_hit;
  assign rd1_hit = bus.wb_wren_i && (bus.wb_waddr_i == bus.rd1_addr_i);
  assign rd2_hit = bus.wb_wren_i && (bus.wb_waddr_i == bus.rd2_addr_i);

  // GPR storage: commit the writeback value on the edge
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        gpr_q[i] <= '0;
      end
    end else if (wr_en) begin
      gpr_q[bus.wb_waddr_i] <= bus.wb_wdata_i;
    end
  end

  // Scoreboard next state: flush beats everything, then clear, then set,
  // so a same-cycle set and clear on one index leaves the new producer busy
  always_comb begin
    busy_d = busy_q;
    if (bus.sb_flush_i) begin
      busy_d = '0;
    end else begin
      if (bus.wb_wren_i) begin
        busy_d = busy_d & ~reg_mask(bus.wb_waddr_i);
      end
      if (bus.sb_set_i && !is_zero_reg(bus.sb_addr_i)) begin
        busy_d = busy_d | reg_mask(bus.sb_addr_i);
      end
    end
    busy_d[REG_ZERO] = 1'b0;
  end

  // Count of busy registers after this cycle's update
  sb_popcount u_popcount (
    .vec_i (busy_d),
    .cnt_o (busy_cnt_d)
  );

  // Scoreboard and busy-count registers
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  // Read port 1: zero for R0/reset, bypass same-cycle write, else array
  always_comb begin
    bus.rd1_data_o = '0;
    if (!rst_n && !is_zero_reg(bus.rd1_addr_i)) begin
      bus.rd1_data_o = rd1_hit ? bus.wb_wdata_i : gpr_q[bus.rd1_addr_i];
    end
  end

  // Read port 2: same selection as port 1
  always_comb begin
    bus.rd2_data_o = '0;
    if (!rst_n && !is_zero_reg(bus.rd2_addr_i)) begin
      bus.rd2_data_o = rd2_hit ? bus.wb_wdata_i : gpr_q[bus.rd2_addr_i];
    end
  end

  // Busy flags: a same-cycle writeback resolves the hazard via the bypass
  always_comb begin
    bus.rd1_busy_o = !rst_n && busy_q[bus.rd1_addr_i] && !rd1_hit;
    bus.rd2_busy_o = !rst_n && busy_q[bus.rd2_addr_i] && !rd2_hit;
  end

  assign bus.busy_cnt_o = busy_cnt_q;

endmodule
